// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU sequencer: control opcode constants, the
// sequencer state enum and helpers that slice an 8-bit instruction into its
// opcode / destination / source fields.
package cpu_pkg;

    // Control opcodes the sequencer reacts to; every other opcode is an ALU write
    localparam logic [3:0] OPCODE_NOP  = 4'h0;
    localparam logic [3:0] OPCODE_JMP  = 4'hE;
    localparam logic [3:0] OPCODE_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } ctrl_state_t;

    // Instruction layout: opcode [7:4], destination [3:2], source [1:0]
    function automatic logic [3:0] instrOpcode(input logic [7:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [1:0] instrDst(input logic [7:0] instr);
        return instr[3:2];
    endfunction

    function automatic logic [1:0] instrSrc(input logic [7:0] instr);
        return instr[1:0];
    endfunction

endpackage

// File: rtl/cpu_ctrl_pc.sv
// cpu_ctrl_pc
// Program counter and retired-instruction counter for the sequencer.
// Ports:
//   i_clk, i_rst     : clock and synchronous active-high reset
//   i_clear          : return the PC to 0 (restart from HALTED)
//   i_load           : load the PC from i_loadAddr (jump)
//   i_inc            : advance the PC by one, wrapping 8'hFF -> 8'h00
//   i_loadAddr       : jump address
//   i_retire         : an instruction completed this cycle
//   o_pc             : current program counter
//   o_retired        : completed-instruction count, wraps at 256
module cpu_ctrl_pc (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_inc,
    input  logic [7:0] i_loadAddr,
    input  logic       i_retire,
    output logic [7:0] o_pc,
    output logic [7:0] o_retired
);

    logic [7:0] r_pc;
    logic [7:0] r_retired;

    // PC register: clear has priority over load, load over increment.
    // The 8-bit add wraps naturally from 8'hFF to 8'h00.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= 8'h00;
        end else if (i_clear) begin
            r_pc <= 8'h00;
        end else if (i_load) begin
            r_pc <= i_loadAddr;
        end else if (i_inc) begin
            r_pc <= r_pc + 8'd1;
        end
    end

    // Retired counter: only reset clears it, so a restart after HALT keeps it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retired <= 8'h00;
        end else if (i_retire) begin
            r_retired <= r_retired + 8'd1;
        end
    end

    assign o_pc      = r_pc;
    assign o_retired = r_retired;

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl
// Four-stage sequencer (fetch, decode, execute, write-back) for the 8-bit
// CPU datapath. Owns the instruction register, drives one-cycle stage
// enables, gates register-file write-back and handles JMP / HALT.
// Ports:
//   i_clk, i_rst              : clock and synchronous active-high reset
//   i_start                   : leave IDLE or HALTED (ignored while busy)
//   o_imem_req, o_imem_addr   : instruction fetch request and address (= pc)
//   i_imem_ready, i_imem_data : fetch completion and fetched instruction
//   o_ir                      : instruction register
//   o_stage_dc/ex/wb          : one-cycle stage enables
//   o_rf_we, o_rf_waddr       : register-file write strobe and index
//   i_jmp_target              : jump address, sampled in write-back
//   o_pc                      : program counter
//   o_halted, o_busy          : status decoded from the state register
//   o_retired                 : completed-instruction count
// Every output comes from registered state only.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [3:0] OP_NOP  = OPCODE_NOP,
    parameter logic [3:0] OP_JMP  = OPCODE_JMP,
    parameter logic [3:0] OP_HALT = OPCODE_HALT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_imem_req,
    output logic [7:0] o_imem_addr,
    input  logic       i_imem_ready,
    input  logic [7:0] i_imem_data,
    output logic [7:0] o_ir,
    output logic       o_stage_dc,
    output logic       o_stage_ex,
    output logic       o_stage_wb,
    output logic       o_rf_we,
    output logic [1:0] o_rf_waddr,
    input  logic [7:0] i_jmp_target,
    output logic [7:0] o_pc,
    output logic       o_halted,
    output logic       o_busy,
    output logic [7:0] o_retired
);

    ctrl_state_t r_state;
    ctrl_state_t w_nextState;
    logic [7:0]  r_ir;
    logic [3:0]  w_opcode;
    logic        w_isJmp;
    logic        w_isHalt;
    logic        w_noWrite;
    logic        w_pcClear;
    logic        w_pcLoad;
    logic        w_pcInc;
    logic        w_retire;

    assign w_opcode  = instrOpcode(r_ir);
    assign w_isJmp   = (w_opcode == OP_JMP);
    assign w_isHalt  = (w_opcode == OP_HALT);
    assign w_noWrite = (w_opcode == OP_NOP) || w_isJmp || w_isHalt;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Instruction register: captures only on a completed fetch, so a stray
    // ready pulse in any other state leaves it untouched
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ir <= 8'h00;
        end else if ((r_state == S_FETCH) && i_imem_ready) begin
            r_ir <= i_imem_data;
        end
    end

    // Next-state and stage decode. Strobes depend on r_state and r_ir only;
    // inputs reach just the next-state and PC-control terms.
    always_comb begin
        w_nextState = r_state;
        o_imem_req  = 1'b0;
        o_stage_dc  = 1'b0;
        o_stage_ex  = 1'b0;
        o_stage_wb  = 1'b0;
        o_rf_we     = 1'b0;
        o_halted    = 1'b0;
        o_busy      = 1'b0;
        w_pcClear   = 1'b0;
        w_pcLoad    = 1'b0;
        w_pcInc     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                o_busy     = 1'b1;
                if (i_imem_ready) begin
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                o_stage_dc  = 1'b1;
                o_busy      = 1'b1;
                w_nextState = S_EXEC;
            end
            S_EXEC: begin
                o_stage_ex  = 1'b1;
                o_busy      = 1'b1;
                w_nextState = S_WB;
            end
            S_WB: begin
                o_stage_wb  = 1'b1;
                o_busy      = 1'b1;
                o_rf_we     = !w_noWrite;
                w_retire    = 1'b1;
                w_pcLoad    = w_isJmp;
                w_pcInc     = !(w_isJmp || w_isHalt);
                w_nextState = w_isHalt ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                o_halted = 1'b1;
                if (i_start) begin
                    w_pcClear   = 1'b1;
                    w_nextState = S_FETCH;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    cpu_ctrl_pc u_pc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_pcClear),
        .i_load     (w_pcLoad),
        .i_inc      (w_pcInc),
        .i_loadAddr (i_jmp_target),
        .i_retire   (w_retire),
        .o_pc       (o_pc),
        .o_retired  (o_retired)
    );

    assign o_imem_addr = o_pc;
    assign o_ir        = r_ir;
    assign o_rf_waddr  = instrDst(r_ir);

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl
// Directed bench for cpu_ctrl: a cycle-by-cycle vector table covering a
// zero-wait program, restart after HALT, wait states, jumps and PC wrap,
// followed by hand-written reset sequences.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       imemReq;
    logic [7:0] imemAddr;
    logic       imemReady;
    logic [7:0] imemData;
    logic [7:0] ir;
    logic       stageDc;
    logic       stageEx;
    logic       stageWb;
    logic       rfWe;
    logic [1:0] rfWaddr;
    logic [7:0] jmpTarget;
    logic [7:0] pc;
    logic       halted;
    logic       busy;
    logic [7:0] retired;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic       rdy;
        logic [7:0] data;
        logic [7:0] jt;
        logic       req;
        logic       dc;
        logic       ex;
        logic       wb;
        logic       we;
        logic [1:0] wa;
        logic [7:0] pc;
        logic [7:0] ir;
        logic       hlt;
        logic       bsy;
        logic [7:0] ret;
    } vec_t;

    localparam int NVEC = 38;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    cpu_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_imem_req   (imemReq),
        .o_imem_addr  (imemAddr),
        .i_imem_ready (imemReady),
        .i_imem_data  (imemData),
        .o_ir         (ir),
        .o_stage_dc   (stageDc),
        .o_stage_ex   (stageEx),
        .o_stage_wb   (stageWb),
        .o_rf_we      (rfWe),
        .o_rf_waddr   (rfWaddr),
        .i_jmp_target (jmpTarget),
        .o_pc         (pc),
        .o_halted     (halted),
        .o_busy       (busy),
        .o_retired    (retired)
    );

    function automatic vec_t mk(
        input logic s, input logic r, input logic [7:0] d, input logic [7:0] j,
        input logic q, input logic c, input logic e, input logic w, input logic we,
        input logic [1:0] wa, input logic [7:0] p, input logic [7:0] i,
        input logic h, input logic b, input logic [7:0] rt);
        vec_t v;
        v.start = s;  v.rdy = r;  v.data = d;  v.jt = j;
        v.req = q;    v.dc = c;   v.ex = e;    v.wb = w;  v.we = we;
        v.wa = wa;    v.pc = p;   v.ir = i;    v.hlt = h; v.bsy = b;
        v.ret = rt;
        return v;
    endfunction

    // Drive one cycle of inputs, let the clock edge take them, then settle
    // on the falling edge where outputs are compared
    task automatic applyStimulus(input vec_t v);
        start     = v.start;
        imemReady = v.rdy;
        imemData  = v.data;
        jmpTarget = v.jt;
        @(posedge clk);
        @(negedge clk);
    endtask

    // imem_addr is held to the expected pc value, not to the DUT's own pc
    task automatic checkOutput(input string name, input vec_t e);
        logic [48:0] act;
        logic [48:0] exp;
        act = {imemReq, stageDc, stageEx, stageWb, rfWe, rfWaddr, pc, imemAddr, ir, halted, busy, retired};
        exp = {e.req, e.dc, e.ex, e.wb, e.we, e.wa, e.pc, e.pc, e.ir, e.hlt, e.bsy, e.ret};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (req dc ex wb we wa pc addr ir halted busy retired)",
                     name, act, exp);
        end
    endtask

    initial begin
        // Program 14, 29, F0 with zero-wait memory; start held in DECODE is ignored
        vecs[0]  = mk(1,1,8'hAA,8'hAA, 1,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,1, 8'd0);
        vecs[1]  = mk(0,1,8'h14,8'hAA, 0,1,0,0,0, 2'd1, 8'h00, 8'h14, 0,1, 8'd0);
        vecs[2]  = mk(1,1,8'hAA,8'hAA, 0,0,1,0,0, 2'd1, 8'h00, 8'h14, 0,1, 8'd0);
        vecs[3]  = mk(0,1,8'hAA,8'hAA, 0,0,0,1,1, 2'd1, 8'h00, 8'h14, 0,1, 8'd0);
        vecs[4]  = mk(0,1,8'hAA,8'hAA, 1,0,0,0,0, 2'd1, 8'h01, 8'h14, 0,1, 8'd1);
        vecs[5]  = mk(0,1,8'h29,8'hAA, 0,1,0,0,0, 2'd2, 8'h01, 8'h29, 0,1, 8'd1);
        vecs[6]  = mk(0,1,8'hAA,8'hAA, 0,0,1,0,0, 2'd2, 8'h01, 8'h29, 0,1, 8'd1);
        vecs[7]  = mk(0,1,8'hAA,8'hAA, 0,0,0,1,1, 2'd2, 8'h01, 8'h29, 0,1, 8'd1);
        vecs[8]  = mk(0,1,8'hAA,8'hAA, 1,0,0,0,0, 2'd2, 8'h02, 8'h29, 0,1, 8'd2);
        vecs[9]  = mk(0,1,8'hF0,8'hAA, 0,1,0,0,0, 2'd0, 8'h02, 8'hF0, 0,1, 8'd2);
        vecs[10] = mk(0,1,8'hAA,8'hAA, 0,0,1,0,0, 2'd0, 8'h02, 8'hF0, 0,1, 8'd2);
        vecs[11] = mk(0,1,8'hAA,8'hAA, 0,0,0,1,0, 2'd0, 8'h02, 8'hF0, 0,1, 8'd2);
        vecs[12] = mk(0,1,8'hAA,8'hAA, 0,0,0,0,0, 2'd0, 8'h02, 8'hF0, 1,0, 8'd3);
        // HALTED ignores ready; start restarts at pc 0 and keeps retired
        vecs[13] = mk(0,1,8'hAA,8'hAA, 0,0,0,0,0, 2'd0, 8'h02, 8'hF0, 1,0, 8'd3);
        vecs[14] = mk(1,1,8'hAA,8'hAA, 1,0,0,0,0, 2'd0, 8'h00, 8'hF0, 0,1, 8'd3);
        // Three wait cycles: req held four cycles, seven cycles for the instruction
        vecs[15] = mk(0,0,8'hAA,8'hAA, 1,0,0,0,0, 2'd0, 8'h00, 8'hF0, 0,1, 8'd3);
        vecs[16] = mk(1,0,8'hAA,8'hAA, 1,0,0,0,0, 2'd0, 8'h00, 8'hF0, 0,1, 8'd3);
        vecs[17] = mk(0,0,8'hAA,8'hAA, 1,0,0,0,0, 2'd0, 8'h00, 8'hF0, 0,1, 8'd3);
        vecs[18] = mk(0,1,8'h10,8'hAA, 0,1,0,0,0, 2'd0, 8'h00, 8'h10, 0,1, 8'd3);
        vecs[19] = mk(0,1,8'hAA,8'hAA, 0,0,1,0,0, 2'd0, 8'h00, 8'h10, 0,1, 8'd3);
        vecs[20] = mk(0,1,8'hAA,8'hAA, 0,0,0,1,1, 2'd0, 8'h00, 8'h10, 0,1, 8'd3);
        vecs[21] = mk(0,1,8'hAA,8'hAA, 1,0,0,0,0, 2'd0, 8'h01, 8'h10, 0,1, 8'd4);
        // JMP at 01 to 05
        vecs[22] = mk(0,1,8'hE0,8'h05, 0,1,0,0,0, 2'd0, 8'h01, 8'hE0, 0,1, 8'd4);
        vecs[23] = mk(0,1,8'hAA,8'h05, 0,0,1,0,0, 2'd0, 8'h01, 8'hE0, 0,1, 8'd4);
        vecs[24] = mk(0,1,8'hAA,8'h05, 0,0,0,1,0, 2'd0, 8'h01, 8'hE0, 0,1, 8'd4);
        vecs[25] = mk(0,1,8'hAA,8'h05, 1,0,0,0,0, 2'd0, 8'h05, 8'hE0, 0,1, 8'd5);
        // JMP at 05 to 40
        vecs[26] = mk(0,1,8'hE0,8'h40, 0,1,0,0,0, 2'd0, 8'h05, 8'hE0, 0,1, 8'd5);
        vecs[27] = mk(0,1,8'hAA,8'h40, 0,0,1,0,0, 2'd0, 8'h05, 8'hE0, 0,1, 8'd5);
        vecs[28] = mk(0,1,8'hAA,8'h40, 0,0,0,1,0, 2'd0, 8'h05, 8'hE0, 0,1, 8'd5);
        vecs[29] = mk(0,1,8'hAA,8'h40, 1,0,0,0,0, 2'd0, 8'h40, 8'hE0, 0,1, 8'd6);
        // JMP with a nonzero dst field still must not write
        vecs[30] = mk(0,1,8'hEC,8'hFF, 0,1,0,0,0, 2'd3, 8'h40, 8'hEC, 0,1, 8'd6);
        vecs[31] = mk(0,1,8'hAA,8'hFF, 0,0,1,0,0, 2'd3, 8'h40, 8'hEC, 0,1, 8'd6);
        vecs[32] = mk(0,1,8'hAA,8'hFF, 0,0,0,1,0, 2'd3, 8'h40, 8'hEC, 0,1, 8'd6);
        vecs[33] = mk(0,1,8'hAA,8'hFF, 1,0,0,0,0, 2'd3, 8'hFF, 8'hEC, 0,1, 8'd7);
        // ALU op at FF wraps the next fetch to 00
        vecs[34] = mk(0,1,8'h10,8'hAA, 0,1,0,0,0, 2'd0, 8'hFF, 8'h10, 0,1, 8'd7);
        vecs[35] = mk(0,1,8'hAA,8'hAA, 0,0,1,0,0, 2'd0, 8'hFF, 8'h10, 0,1, 8'd7);
        vecs[36] = mk(0,1,8'hAA,8'hAA, 0,0,0,1,1, 2'd0, 8'hFF, 8'h10, 0,1, 8'd7);
        vecs[37] = mk(0,0,8'hAA,8'hAA, 1,0,0,0,0, 2'd0, 8'h00, 8'h10, 0,1, 8'd8);

        // Reset with start and a ready pulse present: reset wins
        rst = 1'b1;
        applyStimulus(mk(1,1,8'h14,8'h00, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("reset_state", mk(0,0,8'h00,8'h00, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while fetching (req high, pc 00, retired 8): in-flight work discarded
        rst = 1'b1;
        applyStimulus(mk(0,0,8'hAA,8'hAA, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("rst_mid_fetch", mk(0,0,8'h00,8'h00, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        rst = 1'b0;

        // A late ready pulse in IDLE changes nothing
        applyStimulus(mk(0,1,8'h29,8'hAA, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("late_ready_ignored", mk(0,0,8'h00,8'h00, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        applyStimulus(mk(0,0,8'hAA,8'hAA, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("idle_hold", mk(0,0,8'h00,8'h00, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));

        // Reset and start together stay in IDLE
        rst = 1'b1;
        applyStimulus(mk(1,0,8'hAA,8'hAA, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("rst_beats_start", mk(0,0,8'h00,8'h00, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        rst = 1'b0;

        // Fresh start fetches from 0 with retired cleared, then waits for ready
        applyStimulus(mk(1,0,8'hAA,8'hAA, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("start_after_reset", mk(0,0,8'h00,8'h00, 1,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,1, 8'd0));
        applyStimulus(mk(0,0,8'hAA,8'hAA, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("fetch_wait", mk(0,0,8'h00,8'h00, 1,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,1, 8'd0));
        applyStimulus(mk(0,1,8'h29,8'hAA, 0,0,0,0,0, 2'd0, 8'h00, 8'h00, 0,0, 8'd0));
        checkOutput("fetch_complete", mk(0,0,8'h00,8'h00, 0,1,0,0,0, 2'd2, 8'h00, 8'h29, 0,1, 8'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
